hamming_secded_decoder_pipe: RTL

Parametrised, pipelined successor to the 7-bit Hamming decoder. Extended Hamming codes (SECDED: single-error correct, double-error detect) of generic data width. Adds a valid/ready stream interface, a per-word correct/detect-only mode, error flags, and saturating error counters. Sits between the channel receive path and the data consumer in the error detector/corrector chain.

---
 rtl/hamming_pkg.sv | 33 +++
 rtl/hamming_syndrome.sv | 24 ++
 rtl/hamming_secded_decoder_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming (SECDED) blocks: codeword layout helpers,
// the parity-width sufficiency check and the error classification encoding.
`ifndef HAMMING_PKG_SV
`define HAMMING_PKG_SV

// True when PW Hamming parity bits can cover DW data bits plus the overall parity bit.
`define HAMMING_PAR_W_OK(dw, pw) ((2 ** (pw)) >= ((dw) + (pw) + 1))

package hamming_pkg;

  typedef enum logic [1:0] {
    CLS_CLEAN  = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_DOUBLE = 2'd2
  } err_class_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two Hamming positions in ascending order.
  function automatic int unsigned pos_to_data_idx(input int unsigned pos);
    int unsigned idx;
    idx = 0;
    for (int unsigned q = 1; q < pos; q++) begin
      if (!is_pow2(q)) idx++;
    end
    return idx;
  endfunction

endpackage

`endif

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended Hamming codeword.
module hamming_syndrome #(
  parameter  int DATA_W = 4,
  parameter  int PAR_W  = 3,
  localparam int N      = DATA_W + PAR_W + 1
) (
  input  logic [N-1:0]     cw,
  output logic [PAR_W-1:0] s,
  output logic             p
);

  if (!`HAMMING_PAR_W_OK(DATA_W, PAR_W)) begin : g_par_check
    $error("hamming_syndrome: PAR_W too small for DATA_W");
  end

  always_comb begin
    s = '0;
    for (int i = 1; i < N; i++) begin
      if (cw[i]) s = s ^ PAR_W'(i);
    end
    p = ^cw;
  end

endmodule

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready stream, per-word correct/detect mode,
// error flags and saturating error counters.
module hamming_secded_decoder_pipe
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int PAR_W  = 3,
  parameter  int CNT_W  = 16,
  localparam int N      = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_cw,
  input  logic              in_select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic [PAR_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  if (!`HAMMING_PAR_W_OK(DATA_W, PAR_W)) begin : g_par_check
    $error("hamming_secded_decoder_pipe: PAR_W too small for DATA_W");
  end

  logic              s2_adv;
  logic              s1_adv;
  logic              out_hs;

  logic [PAR_W-1:0]  syn_in;
  logic              par_in;
  logic [DATA_W-1:0] raw_in;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s1_mode;

  err_class_e        cls;
  logic              do_flip;
  logic [DATA_W-1:0] dec_data;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid && out_ready;

  hamming_syndrome #(
    .DATA_W (DATA_W),
    .PAR_W  (PAR_W)
  ) u_syndrome (
    .cw (in_cw),
    .s  (syn_in),
    .p  (par_in)
  );

  // Only the data positions are carried forward; parity positions live on in the syndrome.
  always_comb begin
    raw_in = '0;
    for (int pos = 1; pos < N; pos++) begin
      if (!is_pow2(pos)) raw_in[pos_to_data_idx(pos)] = in_cw[pos];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_mode  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= raw_in;
        s1_syn  <= syn_in;
        s1_par  <= par_in;
        s1_mode <= in_select;
      end
    end
  end

  // A syndrome pointing past the last position can only come from a shortened code and
  // means at least two bits flipped.
  always_comb begin
    cls = CLS_CLEAN;
    if (!s1_par) begin
      cls = (s1_syn == '0) ? CLS_CLEAN : CLS_DOUBLE;
    end else if (int'(s1_syn) > N - 1) begin
      cls = CLS_DOUBLE;
    end else begin
      cls = CLS_SINGLE;
    end
  end

  assign do_flip = (cls == CLS_SINGLE) && s1_mode;

  always_comb begin
    dec_data = s1_data;
    for (int pos = 1; pos < N; pos++) begin
      if (!is_pow2(pos) && do_flip && (s1_syn == PAR_W'(pos))) begin
        dec_data[pos_to_data_idx(pos)] = ~s1_data[pos_to_data_idx(pos)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_single   <= 1'b0;
      out_double   <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= dec_data;
        out_single   <= (cls == CLS_SINGLE);
        out_double   <= (cls == CLS_DOUBLE);
        out_syndrome <= s1_syn;
      end
    end
  end

  // Clear wins over a same-cycle delivery; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (out_hs) begin
      if (out_single && (cnt_single != '1)) cnt_single <= cnt_single + CNT_W'(1);
      if (out_double && (cnt_double != '1)) cnt_double <= cnt_double + CNT_W'(1);
    end
  end

endmodule
